// File: rtl/ym_clk_phase_gen.sv
// Samples phi_in into MCLK and emits non-overlapping c1/c2 enables, a slot counter with frame sync, and a lost-clock flag.
// Latency: 3 MCLK edges from phi_in rising to c1/c2; no backpressure, all outputs free-running.
module ym_clk_phase_gen #(
    parameter int PRESCALE  = 4,
    parameter int NUM_SLOTS = 18,
    parameter int SLOT_W    = 5,
    parameter int TIMEOUT   = 1024
) (
    input  logic              MCLK,
    input  logic              rst,
    input  logic              phi_in,
    output logic              c1,
    output logic              c2,
    output logic [SLOT_W-1:0] slot,
    output logic              sync,
    output logic              clk_lost
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0]     P_LAST    = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]     P_HALF    = PW'(PRESCALE / 2);
    localparam logic [SLOT_W-1:0] S_LAST    = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [15:0]       IDLE_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]       IDLE_MAX  = 16'(TIMEOUT);

    logic          s1, s2, s3;
    logic [PW-1:0] pcnt;
    logic [15:0]   idle_cnt;
    logic          tick;
    logic          c1_hit;
    logic          c2_hit;

    assign tick   = s2 & ~s3;
    assign c1_hit = tick & (pcnt == '0);
    assign c2_hit = tick & (pcnt == P_HALF);

    always_ff @(posedge MCLK) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            pcnt     <= '0;
            c1       <= 1'b0;
            c2       <= 1'b0;
            slot     <= '0;
            sync     <= 1'b0;
            idle_cnt <= '0;
            clk_lost <= 1'b0;
        end else begin
            s1 <= phi_in;
            s2 <= s1;
            s3 <= s2;

            if (tick)
                pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;

            c1   <= c1_hit;
            c2   <= c2_hit;
            sync <= c2_hit & (slot == S_LAST);
            if (c2_hit)
                slot <= (slot == S_LAST) ? '0 : slot + 1'b1;

            // pcnt/slot only move on tick, so a stalled clock freezes the phase in place
            if (tick)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 16'd1;
            clk_lost <= ((idle_cnt == IDLE_LAST) & ~tick) | (clk_lost & ~tick);
        end
    end
endmodule

// File: doc/ym_clk_phase_gen.md
Name: ym_clk_phase_gen

Overview:
- Upstream clock-phase generator for the ym_* primitive library (shift registers, counters, latches).
- Samples the chip's external clock pin in the MCLK domain and produces the single-cycle, non-overlapping c1/c2 enables those primitives consume.
- Also produces a slot counter with a frame sync pulse, plus a lost-clock watchdog.

Parameters:
- PRESCALE, 4, phi_in rising edges per full c1/c2 cycle; must be even and >= 2.
- NUM_SLOTS, 18, slots per frame; slot counts 0..NUM_SLOTS-1.
- SLOT_W, 5, width of slot output; must satisfy 2^SLOT_W >= NUM_SLOTS.
- TIMEOUT, 1024, MCLK cycles without a phi_in edge before clk_lost asserts; range 1..65535.

Ports:
- MCLK  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- phi_in  input  1  external chip clock pin; asynchronous to MCLK.
- c1  output  1  phase-1 enable, one MCLK cycle wide.
- c2  output  1  phase-2 enable, one MCLK cycle wide; never high in the same cycle as c1.
- slot  output  SLOT_W  current slot index.
- sync  output  1  one-cycle pulse, coincident with the c2 cycle in which slot wraps to 0.
- clk_lost  output  1  high while phi_in has stalled for >= TIMEOUT MCLK cycles.

Behaviour:
- Reset: synchronous, active-high.
  - While rst is high at a rising edge, all flops clear: s1, s2, s3, pcnt, c1, c2, slot, sync, idle counter and clk_lost.
  - All outputs read 0 in the cycle after that edge.
  - rst asserted mid-frame aborts the frame. There are no partial pulses: c1/c2/sync are 0 the cycle after the reset edge.
- Synchroniser: s1<=phi_in, s2<=s1, s3<=s2 on every edge.
  - tick = s2 & ~s3 (combinational), one cycle per phi_in rising edge.
  - Because the flops reset to 0, phi_in already high at reset release produces exactly one tick.
- Prescaler: pcnt has width clog2(PRESCALE).
  - On tick: pcnt <= (pcnt==PRESCALE-1) ? 0 : pcnt+1. Otherwise pcnt holds.
- Phase outputs (registered):
  - c1 <= tick & (pcnt==0).
  - c2 <= tick & (pcnt==PRESCALE/2).
  - Each pulse is exactly one MCLK cycle wide.
  - c1 and c2 alternate, separated by PRESCALE/2 ticks. PRESCALE=2 still gives distinct cycles.
- Latency:
  - phi_in high before edge k is sampled into s1 at k, and tick is high during the cycle after edge k+1.
  - The resulting c1/c2 pulse is visible after edge k+2, i.e. 3 edges of latency.
- Slot counter:
  - Updates at the same edge that sets c2: slot <= (slot==NUM_SLOTS-1) ? 0 : slot+1.
  - slot therefore changes in the same cycle c2 is high. It holds otherwise.
- sync:
  - sync <= (c2 condition) & (slot==NUM_SLOTS-1).
  - High in exactly the cycle slot becomes 0: one pulse per NUM_SLOTS c2 pulses.
- Watchdog: 16-bit idle counter.
  - Clears to 0 on tick. Otherwise increments, saturating at TIMEOUT.
  - clk_lost <= (idle counter == TIMEOUT-1 and no tick) | (clk_lost & ~tick).
  - So clk_lost rises TIMEOUT cycles after the last tick and falls in the cycle after the next tick.
  - pcnt and slot hold their values while clk_lost is high; the phase resumes where it stopped, with no re-sync.
- phi_in glitches shorter than one MCLK period may be missed. phi_in must hold each level for >= 2 MCLK cycles; behaviour outside that is undefined but must not produce simultaneous c1 and c2.
- No overflow is possible: pcnt and slot always wrap explicitly, and the idle counter saturates.

Test Plan:
- Reset release with phi_in low, then phi_in toggling every 4 MCLK (PRESCALE=4) -> first c1 three edges after first rising-edge sample; c2 exactly 16 MCLK later; c1 period 32 MCLK; c1 & c2 never both high.
- Run 18 c2 pulses from reset (NUM_SLOTS=18) -> slot sequence 1,2,...,17,0; sync high only in the cycle slot becomes 0; second sync 18 c2 pulses after the first.
- phi_in held high across rst deassertion -> exactly one tick, one c1 pulse, pcnt=1; no c2 until two more phi_in rising edges.
- Stop phi_in with TIMEOUT=16 -> clk_lost high exactly 16 MCLK after the last tick; no c1/c2 while stalled; on restart clk_lost low the cycle after the first tick and slot continues from the held value.
- Assert rst for one cycle at slot=9, mid c1→c2 interval -> next cycle: slot=0, c1=c2=sync=clk_lost=0; the next tick produces c1, not c2.
- PRESCALE=2, phi_in toggling every 2 MCLK -> c1 and c2 alternate on consecutive ticks, each one cycle wide, never overlapping; slot increments once per c2.
